// File: rtl/select_arb.sv
// N-channel registered selector: picks one requesting channel per cycle by
// fixed priority, round-robin or forced index, and registers its word.
module select_arb #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int IDXW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic                 force_en,
  input  logic [IDXW-1:0]      force_sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDXW-1:0]      out_sel
);

  // Handshake: a channel transfers when in_valid[i] && in_ready[i]; the output
  // word transfers when out_valid && out_ready. in_ready is one-hot or zero.

  logic [NCH-1:0]   elig;
  logic             any_elig;
  logic             load;
  logic [IDXW-1:0]  grant_idx;
  logic [IDXW-1:0]  ptr;
  logic [WIDTH-1:0] grant_data;
  int               rr_idx;

  assign load     = !out_valid || out_ready;
  assign any_elig = |elig;

  // A force_sel beyond the last channel matches nothing, leaving elig empty.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NCH; i++)
      elig[i] = in_valid[i] && (!force_en || (int'(force_sel) == i));
  end

  // Searching from the far end lets the nearest eligible channel win last.
  always_comb begin
    grant_idx = '0;
    rr_idx    = 0;
    if (!mode) begin
      for (int i = NCH - 1; i >= 0; i--)
        if (elig[i]) grant_idx = IDXW'(i);
    end else begin
      for (int k = NCH; k >= 1; k--) begin
        rr_idx = (int'(ptr) + k) % NCH;
        if (elig[rr_idx]) grant_idx = IDXW'(rr_idx);
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NCH; i++)
      if (grant_idx == IDXW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NCH; i++)
      in_ready[i] = rst_n && load && any_elig && (grant_idx == IDXW'(i));
  end

  // ptr starts at the last channel so the first round-robin grant is ch0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= IDXW'(NCH - 1);
    end else if (load) begin
      if (any_elig) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant_idx;
        ptr       <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_select_arb.sv
// Self-checking bench for select_arb: reference arbiter model plus a queue of
// expected output words, directed scenarios followed by random traffic.
module tb_select_arb;
  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int IDXW  = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic                 force_en;
  logic [IDXW-1:0]      force_sel;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [IDXW-1:0]      out_sel;

  select_arb #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .force_en(force_en),
    .force_sel(force_sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sel(out_sel)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [IDXW+WIDTH-1:0] exp_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  bit              m_valid;
  int              m_ptr;
  logic [WIDTH-1:0] m_data;
  logic [IDXW-1:0]  m_sel;
  logic [NCH-1:0]   last_rdy;
  bit               refresh;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_ptr   = NCH - 1;
    m_data  = '0;
    m_sel   = '0;
    exp_q.delete();
  endtask

  task automatic set_data(input int ch, input logic [WIDTH-1:0] d);
    in_data[ch*WIDTH +: WIDTH] = d;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    logic [NCH-1:0] elig;
    logic [NCH-1:0] exp_rdy;
    logic [IDXW+WIDTH-1:0] w;
    int g;
    int idx;
    bit load_m;
    bit xfer;
    #1;
    load_m = !m_valid || out_ready;
    for (int i = 0; i < NCH; i++)
      elig[i] = in_valid[i] && (!force_en || force_sel == IDXW'(i));
    g = -1;
    if (!mode) begin
      for (int i = 0; i < NCH; i++)
        if (g < 0 && elig[i]) g = i;
    end else begin
      for (int k = 1; k <= NCH; k++) begin
        idx = (m_ptr + k) % NCH;
        if (g < 0 && elig[idx]) g = idx;
      end
    end
    xfer = load_m && (g >= 0);
    exp_rdy = '0;
    if (xfer) exp_rdy[g] = 1'b1;
    last_rdy = in_ready;
    check_eq("in_ready", in_ready, exp_rdy);
    if (xfer) exp_q.push_back({g[IDXW-1:0], in_data[g*WIDTH +: WIDTH]});
    @(posedge clk);
    #1;
    if (load_m) m_valid = xfer;
    check_eq("out_valid", out_valid, m_valid);
    if (xfer) begin
      if (exp_q.size() == 0) begin
        check_eq("queue_empty", 1, 0);
      end else begin
        w = exp_q.pop_front();
        m_data = w[WIDTH-1:0];
        m_sel  = w[IDXW+WIDTH-1:WIDTH];
        m_ptr  = g;
        check_eq("out_data", out_data, m_data);
        check_eq("out_sel", out_sel, m_sel);
      end
      if (refresh) begin
        set_data(g, WIDTH'($urandom_range(0, 255)));
        in_valid[g] = 1'($urandom_range(0, 1));
      end
    end else if (m_valid) begin
      check_eq("hold_data", out_data, m_data);
      check_eq("hold_sel", out_sel, m_sel);
    end
    @(negedge clk);
  endtask

  int rr_exp[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = '1; mode = 1'b1;
    force_en = 1'b0; force_sel = '0; out_ready = 1'b1; refresh = 1'b0;
    model_reset();
    for (int i = 0; i < NCH; i++) set_data(i, WIDTH'(8'hA0 + i));
    #12;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_sel", out_sel, 0);
    check_eq("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // round-robin, all channels valid
    for (int i = 0; i < 6; i++) begin
      cycle();
      check_eq("rr_sel", out_sel, rr_exp[i]);
      check_eq("rr_valid", out_valid, 1);
    end

    // fixed priority: ch1 beats ch3 indefinitely
    mode = 1'b0; in_valid = 4'b1010;
    set_data(1, 8'h11); set_data(3, 8'h33);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("fp_rdy", last_rdy, 4'b0010);
      check_eq("fp_data", out_data, 8'h11);
      check_eq("fp_sel", out_sel, 1);
    end

    // backpressure holding 0x22
    in_valid = 4'b0100; set_data(2, 8'h22);
    cycle();
    check_eq("bp_load", out_data, 8'h22);
    out_ready = 1'b0; in_valid = 4'b1111; set_data(0, 8'h44);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("bp_hold", out_data, 8'h22);
      check_eq("bp_rdy", last_rdy, 4'b0000);
    end
    out_ready = 1'b1;
    cycle();
    check_eq("bp_resume_rdy", last_rdy, 4'b0001);
    check_eq("bp_resume_valid", out_valid, 1);
    check_eq("bp_resume_data", out_data, 8'h44);

    // forced channel
    force_en = 1'b1; force_sel = 2'd2; in_valid = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check_eq("force_rdy", last_rdy, 4'b0100);
    end
    in_valid = 4'b1011;
    cycle();
    check_eq("force_none_rdy", last_rdy, 4'b0000);
    check_eq("force_drain", out_valid, 0);
    force_en = 1'b0;

    // random traffic, producers hold until accepted
    refresh = 1'b1;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NCH; i++)
        if (!in_valid[i] && $urandom_range(0, 2) == 0) begin
          set_data(i, WIDTH'($urandom_range(0, 255)));
          in_valid[i] = 1'b1;
        end
      mode      = 1'($urandom_range(0, 1));
      force_en  = ($urandom_range(0, 4) == 0);
      force_sel = IDXW'($urandom_range(0, NCH - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    refresh = 1'b0;

    // async reset mid-stream
    mode = 1'b1; force_en = 1'b0; out_ready = 1'b1; in_valid = 4'b1111;
    cycle(); cycle();
    check_eq("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", out_valid, 0);
    check_eq("async_rst_rdy", in_ready, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check_eq("post_rst_rdy", last_rdy, 4'b0001);
    check_eq("post_rst_sel", out_sel, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/select_arb.md
# select_arb

Parametrised N-channel, W-bit registered selector with valid/ready handshaking. It supersedes the 2:1 combinational `select`. Each cycle it picks one requesting input channel by fixed-priority, round-robin or forced-channel selection, and registers that channel's data into a single output stage. The block sits between multiple producers and one consumer, with one cycle of latency and full throughput.

## Interface
- `WIDTH`, 8, data width per channel (≥1)
- `NCH`, 4, number of input channels (≥2)
- `IDXW`, `$clog2(NCH)`, width of channel-index signals (derived; do not override)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_data`  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- `in_valid`  in  NCH  per-channel request
- `in_ready`  out  NCH  per-channel accept; one-hot or zero
- `mode`  in  1  0 = fixed priority (ch0 highest), 1 = round-robin
- `force_en`  in  1  1 = only channel `force_sel` is eligible
- `force_sel`  in  IDXW  forced channel index
- `out_data`  out  WIDTH  registered selected data
- `out_valid`  out  1  output register holds a word
- `out_ready`  in  1  consumer accept
- `out_sel`  out  IDXW  source channel of current `out_data`

## Operation
- Load enable: `load = !out_valid || out_ready`.
- Eligible set `E`:
  - If `force_en`=1: `E = in_valid & onehot(force_sel)`. If `force_sel` ≥ NCH, `E` is empty.
  - If `force_en`=0: `E = in_valid`.
- Winner `g` (combinational, valid only when `E` is non-empty):
  - `mode`=0: lowest set index in `E`.
  - `mode`=1: first set index in `E` searching `ptr+1, ptr+2, …` with wrap modulo NCH.
- `in_ready[g] = load && E!=0`. All other `in_ready` bits are 0. `in_ready` may depend combinationally on `out_ready`, `in_valid`, `mode`, `force_*`.
- Transfer on channel g: `in_valid[g] && in_ready[g]`. On the next edge, `out_data <= in_data[g]`, `out_sel <= g`, `out_valid <= 1`, `ptr <= g`.
- `ptr` updates on every transfer regardless of mode or force. The round-robin order therefore continues from the last-served channel after a mode change.
- No transfer and `out_ready`=1: `out_valid <= 0`. `out_data` and `out_sel` hold their last values.
- Stall (`out_valid && !out_ready`): `out_data`, `out_sel` and `out_valid` remain stable and all `in_ready` are 0.
- Inputs not granted are not consumed. Producers hold `in_valid`/`in_data` until accepted.

## Timing
- Reset (async assert, sync-safe deassert): `out_valid`=0, `out_data`=0, `out_sel`=0, `ptr`=NCH-1, so the first RR grant goes to ch0. `in_ready` is all 0 while `rst_n`=0.
- Latency: input accepted at edge k appears on `out_data` with `out_valid`=1 after edge k.
- Throughput: one word per cycle when `out_ready` is held at 1 (simultaneous drain and load in the same cycle).
- Simultaneous events: output drain and new load in one cycle produce back-to-back `out_valid`=1 with no bubble.
- `mode`/`force_*` changes take effect in the same cycle's arbitration. A word already registered is unaffected.
- Reset mid-operation: the registered word is discarded and `out_valid` drops immediately (asynchronous). After release, arbitration restarts from ch0.
- RR wrap-around: with `ptr`=NCH-1, the search order is 0,1,…,NCH-1.

## Test plan
- Reset: drive `rst_n`=0 with all `in_valid`=1 -> `out_valid`=0, `out_data`=0, `out_sel`=0, `in_ready`=0000. After release with `out_ready`=1 and `mode`=1, the first grant is ch0.
- Fixed priority (NCH=4, WIDTH=8): `in_valid`=1010, data ch1=0x11, ch3=0x33, `out_ready`=1 -> grant ch1 (`in_ready`=0010), next cycle `out_data`=0x11 and `out_sel`=1. Hold ch1 valid -> ch3 is never granted.
- Round-robin: all four channels valid continuously, `mode`=1, `out_ready`=1 -> `out_sel` sequence 0,1,2,3,0,1 with `out_valid` continuously 1.
- Backpressure: `out_valid`=1 holding 0x22, drop `out_ready` for 3 cycles while inputs are valid -> `out_data` stays 0x22, `in_ready`=0000. On `out_ready`=1, the next word loads on the same edge as the drain.
- Force: `force_en`=1, `force_sel`=2, `in_valid`=1111 -> only ch2 is granted. `force_sel`=2 with `in_valid`=1011 -> no grant and `out_valid` falls to 0 after drain.
- Async reset mid-stream: assert `rst_n`=0 between clock edges while `out_valid`=1 -> `out_valid` is 0 before the next edge and `ptr` is reset, so the first post-reset RR grant is ch0.
